rom_upload_bridge: RTL
======================

Name: rom_upload_bridge

Overview:
- Receives the ROM image byte stream from the control module's host side.
- Packs the bytes into 16-bit big-endian words, buffers them in a small FIFO, and writes them into SDRAM through the controller's ROM-write toggle handshake (romwr_*).
- Raises host_bootdone once the image is fully committed; that signal releases the 68000 from reset.
- Sits between the control module and the SDRAM controller, on the memory clock.

Parameters:
- FIFO_DEPTH, 4: word FIFO entries. Must be a power of two, at least 2.
- ADDR_BITS, 21: word address width (romwr_a[21:1]).
- SWAP_BYTES, 0: 0 puts the first byte in d[15:8]; 1 puts it in d[7:0].
- PAD_BYTE, 8'hFF: fill value for the missing half of a trailing odd byte.

Ports:
- clk  in  1  memory clock
- reset_n  in  1  asynchronous active-low reset
- boot_start  in  1  one-cycle pulse: begin a new upload at word address 0
- boot_end  in  1  one-cycle pulse: the host has sent its last byte
- host_data  in  8  image byte
- host_valid  in  1  host_data is valid
- host_ready  out  1  byte accepted on a clock edge where host_valid and host_ready are both 1
- romwr_req  out  1  toggle request to the SDRAM controller
- romwr_ack  in  1  controller toggles this to match romwr_req when the write completes
- romwr_we  out  1  write enable, constant 1 outside reset
- romwr_a  out  ADDR_BITS  word address [21:1]
- romwr_d  out  16  write data
- host_bootdone  out  1  image fully written
- word_count  out  ADDR_BITS  words committed (acked) in the current upload
- overflow  out  1  sticky: bytes arrived after the address space was full

Behaviour:
- Reset values: romwr_req=0, romwr_we=0, romwr_a=0, romwr_d=0, host_ready=0, host_bootdone=0, word_count=0, overflow=0. The FIFO is empty, the byte phase is even, and the state is IDLE. After reset romwr_we=1.
- States:
  - IDLE: boot_start -> LOAD. boot_end -> DONE with zero words.
  - LOAD: boot_end -> FLUSH.
  - FLUSH: once the FIFO is empty, no write is outstanding, and no half-word is pending -> DONE.
  - DONE: host_bootdone=1. boot_start -> LOAD.
- boot_start has priority over boot_end in the same cycle.
- boot_start in any state:
  - Clears the FIFO, the byte phase, the fill address, word_count, overflow and host_bootdone.
  - An outstanding write is not abandoned. No new toggle is issued until romwr_ack==romwr_req.
- host_ready = (state==LOAD) and FIFO not full. It is forced to 1 in LOAD while overflow=1, and bytes accepted then are discarded.
- Byte packing:
  - Even byte: latched in a holding register.
  - Odd byte: the word is formed and pushed on the same edge.
  - On entry to FLUSH with a pending even byte, push {byte, PAD_BYTE}, honouring SWAP_BYTES.
- Fill address increments per pushed word.
- When the fill address would pass 2^ADDR_BITS-1:
  - The last word is still pushed.
  - Further pushes are dropped and overflow=1.
  - There is no wrap.
- SDRAM issue:
  - When romwr_req==romwr_ack and the FIFO is non-empty, pop, load romwr_a/romwr_d, and toggle romwr_req, all on the same edge.
  - Only one write is outstanding at a time.
  - romwr_a and romwr_d are held stable until ack matches.
  - word_count increments on the cycle ack is observed to equal req.
- Latency: a word pushed at edge E toggles romwr_req at edge E+1 at the earliest, provided nothing is outstanding.
- FIFO full and pop in the same cycle: a push is allowed only if not full at the start of the cycle (no bypass).
- An ack arriving while req==ack (spurious) is ignored.

Test Plan:
- Basic upload:
  - Stimulus: reset; boot_start; bytes 12,34,56,78; boot_end; controller acks 3 cycles after each toggle.
  - Required: writes (a=0,d=16'h1234) then (a=1,d=16'h5678). romwr_req toggles 2 times. word_count=2. host_bootdone=1 after the second ack.
- Odd length:
  - Stimulus: bytes AB,CD,EF; boot_end.
  - Required: third write a=2, d=16'hEFFF. host_bootdone rises only after that ack.
- Back-pressure:
  - Stimulus: ack held off for 50 cycles while the host streams continuously.
  - Required: host_ready drops after 4 words are buffered, with 1 write outstanding. No byte is lost or duplicated. Addresses are contiguous.
- SWAP_BYTES=1:
  - Stimulus: bytes 12,34.
  - Required: d=16'h3412.
- Restart mid-load:
  - Stimulus: boot_start with a write outstanding and 2 words buffered.
  - Required: no new toggle until ack. The next write uses a=0 with new data. word_count=0. Buffered words are never written.
- Overflow and reset:
  - Stimulus: ADDR_BITS=3; push 9 words.
  - Required: addresses 0..7 written, overflow=1, and host_ready stays 1.
  - Stimulus: assert reset_n=0 mid-write.
  - Required: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/rom_upload_bridge.sv
// rtl/rom_upload_bridge.sv - packs host ROM bytes into 16-bit words and writes them to SDRAM via the romwr toggle handshake
module rom_upload_bridge #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         ADDR_BITS  = 21,
    parameter int         SWAP_BYTES = 0,
    parameter logic [7:0] PAD_BYTE   = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 boot_start,
    input  logic                 boot_end,
    input  logic [7:0]           host_data,
    input  logic                 host_valid,
    output logic                 host_ready,
    output logic                 romwr_req,
    input  logic                 romwr_ack,
    output logic                 romwr_we,
    output logic [ADDR_BITS-1:0] romwr_a,
    output logic [15:0]          romwr_d,
    output logic                 host_bootdone,
    output logic [ADDR_BITS-1:0] word_count,
    output logic                 overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0]          PTR_ONE  = 1;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;
    state_t state, state_nxt;

    logic [15:0]          mem [FIFO_DEPTH];
    logic [PW:0]          wptr, rptr;
    logic                 phase;
    logic [7:0]           hold;
    logic [ADDR_BITS-1:0] fill_addr, rd_addr;
    logic                 addr_full;
    logic                 busy, stale;
    logic                 full, empty, link_idle;
    logic                 accept, byte_keep, odd_push, pad_push, push, issue, complete;
    logic [15:0]          push_word;

    function automatic logic [15:0] pack(input logic [7:0] first, input logic [7:0] second);
        return (SWAP_BYTES != 0) ? {second, first} : {first, second};
    endfunction

    assign empty     = (wptr == rptr);
    assign full      = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign link_idle = (romwr_req == romwr_ack);

    // Once overflowed, the host is drained freely so it never stalls on a full address space.
    assign host_ready = (state == S_LOAD) && (overflow || !full);
    assign accept     = host_valid && host_ready;
    assign byte_keep  = accept && !addr_full;
    assign odd_push   = byte_keep && phase;
    assign pad_push   = (state == S_FLUSH) && phase && !full && !addr_full;
    assign push       = (odd_push || pad_push) && !boot_start;
    assign push_word  = pack(hold, odd_push ? host_data : PAD_BYTE);

    assign issue    = link_idle && !empty && !boot_start;
    assign complete = busy && link_idle;

    assign host_bootdone = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        if (boot_start) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_IDLE:  if (boot_end) state_nxt = S_DONE;
                S_LOAD:  if (boot_end) state_nxt = S_FLUSH;
                S_FLUSH: if (empty && !busy && !phase) state_nxt = S_DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[PW-1:0]] <= push_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            wptr       <= '0;
            rptr       <= '0;
            phase      <= 1'b0;
            hold       <= '0;
            fill_addr  <= '0;
            rd_addr    <= '0;
            addr_full  <= 1'b0;
            busy       <= 1'b0;
            stale      <= 1'b0;
            romwr_req  <= 1'b0;
            romwr_we   <= 1'b0;
            romwr_a    <= '0;
            romwr_d    <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state    <= state_nxt;
            romwr_we <= 1'b1;

            // A write issued before a restart belongs to the old image and is not counted.
            if (complete) begin
                busy  <= 1'b0;
                stale <= 1'b0;
                if (!stale) word_count <= word_count + ADDR_ONE;
            end

            if (issue) begin
                rptr      <= rptr + PTR_ONE;
                romwr_a   <= rd_addr;
                romwr_d   <= mem[rptr[PW-1:0]];
                romwr_req <= ~romwr_req;
                rd_addr   <= rd_addr + ADDR_ONE;
                busy      <= 1'b1;
            end

            if (boot_start) begin
                wptr       <= '0;
                rptr       <= '0;
                phase      <= 1'b0;
                fill_addr  <= '0;
                rd_addr    <= '0;
                addr_full  <= 1'b0;
                word_count <= '0;
                overflow   <= 1'b0;
                stale      <= busy && !link_idle;
            end else begin
                if (byte_keep) begin
                    phase <= ~phase;
                    if (!phase) hold <= host_data;
                end
                if (pad_push) phase <= 1'b0;
                if (push) begin
                    wptr      <= wptr + PTR_ONE;
                    fill_addr <= fill_addr + ADDR_ONE;
                    if (&fill_addr) addr_full <= 1'b1;
                end
                if (accept && addr_full) overflow <= 1'b1;
            end
        end
    end

endmodule
